// File: rtl/sysid_boot_check.sv
// Avalon-MM master that reads the sysid ID and timestamp words after reset or on request
// and compares them with build-time constants, latching flags and raw values.
module sysid_boot_check #(
  parameter logic [31:0] EXPECTED_ID    = 32'd1768888067,
  parameter logic [31:0] EXPECTED_TS    = 32'd1227733144,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Counter value at which the current stall cycle becomes the Nth one.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRdId, StRdTs, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              read_q, read_d;
  logic              addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;
  logic              launch;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    read_d     = read_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    launch     = 1'b0;

    unique case (state_q)
      StIdle: launch = start | pending_q;
      StRdId, StRdTs: begin
        if (!avm_waitrequest) begin
          cnt_d = '0;
          if (state_q == StRdId) begin
            id_value_d = avm_readdata;
            addr_d     = 1'b1;
            state_d    = StRdTs;
          end else begin
            ts_value_d = avm_readdata;
            read_d     = 1'b0;
            state_d    = StCheck;
          end
        end else if (timeout_hit) begin
          // Abandon the read; compare flags stay cleared from launch.
          read_d    = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          fail_d    = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCheck: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TS);
        pass_d  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
        fail_d  = !((id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS));
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: launch = start;
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d   = StRdId;
      pending_d = 1'b0;
      read_d    = 1'b1;
      addr_d    = 1'b0;
      cnt_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= AUTO_START;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = (state_q == StRdId) || (state_q == StRdTs) || (state_q == StCheck);
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
